// File: rtl/sysref_lock_ctrl.sv
// SYSREF period qualification: measure, verify, lock, then forward one pulse per good edge.
// Missing, early, late and absent edges land in a sticky error code.
//
// state | meaning
// ------+-----------------------------------------------------------
// 0     | IDLE       : disarmed, counters cleared
// 1     | WAIT_FIRST : armed, waiting for the first SYSREF edge
// 2     | MEASURE    : timing the first full period
// 3     | VERIFY     : counting in-tolerance periods against period_ref
// 4     | LOCKED     : forwarding qualified edges on sysref_out
// 5     | ERROR      : sticky err/err_code, waits for clear
module sysref_lock_ctrl #(
  parameter int CNT_W      = 16,
  parameter int LOCK_EDGES = 4,
  parameter int PERIOD_TOL = 1,
  parameter int MIN_PERIOD = 4
) (
  input  logic             pl_clk,
  input  logic             pl_rstn,
  input  logic             sysref_adc,
  input  logic             arm,
  input  logic             clear,
  output logic             sysref_out,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] period_ref,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_VERIFY  = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam logic [1:0] E_TIMEOUT = 2'd1;
  localparam logic [1:0] E_SHORT   = 2'd2;
  localparam logic [1:0] E_PERIOD  = 2'd3;

  localparam int                  MATCH_W    = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]    MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W:0]      TOL_X      = (CNT_W+1)'(PERIOD_TOL);
  localparam logic [MATCH_W-1:0]  MATCH_LAST = MATCH_W'(LOCK_EDGES - 1);

  logic               q1, q2, sr_edge;
  logic [CNT_W-1:0]   cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [2:0]         state_nxt;
  logic               err_set, ref_load, match_inc, fire, locked_nxt;
  logic [1:0]         code_nxt;
  logic [CNT_W:0]     cnt_x, ref_x, diff, late_lim;
  logic               in_tol, late;

  assign sr_edge = q1 & ~q2;

  // One extra bit keeps the difference and the late limit free of wrap-around.
  assign cnt_x    = {1'b0, cnt};
  assign ref_x    = {1'b0, period_ref};
  assign diff     = (cnt_x >= ref_x) ? (cnt_x - ref_x) : (ref_x - cnt_x);
  assign late_lim = ref_x + TOL_X;
  assign in_tol   = (diff <= TOL_X);
  assign late     = (cnt_x > late_lim);

  always_ff @(posedge pl_clk or negedge pl_rstn) begin
    if (!pl_rstn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    code_nxt  = 2'd0;
    ref_load  = 1'b0;
    match_inc = 1'b0;
    if (state != S_ERROR && !arm) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (sr_edge) state_nxt = S_MEASURE;
          else if (cnt == CNT_MAX) begin
            err_set  = 1'b1;
            code_nxt = E_TIMEOUT;
          end
        end
        S_MEASURE: begin
          if (sr_edge) begin
            if (cnt < MIN_P) begin
              err_set  = 1'b1;
              code_nxt = E_SHORT;
            end else begin
              ref_load  = 1'b1;
              state_nxt = S_VERIFY;
            end
          end else if (cnt == CNT_MAX) begin
            err_set  = 1'b1;
            code_nxt = E_TIMEOUT;
          end
        end
        S_VERIFY: begin
          if (sr_edge) begin
            if (in_tol) begin
              match_inc = 1'b1;
              if (match_cnt == MATCH_LAST) state_nxt = S_LOCKED;
            end else begin
              err_set  = 1'b1;
              code_nxt = E_PERIOD;
            end
          end else if (late) begin
            err_set  = 1'b1;
            code_nxt = E_PERIOD;
          end
        end
        S_LOCKED: begin
          if ((sr_edge && !in_tol) || (!sr_edge && late)) begin
            err_set  = 1'b1;
            code_nxt = E_PERIOD;
          end
        end
        S_ERROR: if (clear) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
      if (err_set) state_nxt = S_ERROR;
    end
  end

  always_comb begin
    fire       = (state == S_LOCKED) && arm && sr_edge && in_tol;
    locked_nxt = (state_nxt == S_LOCKED);
  end

  always_ff @(posedge pl_clk or negedge pl_rstn) begin
    if (!pl_rstn) begin
      q1         <= 1'b0;
      q2         <= 1'b0;
      cnt        <= '0;
      match_cnt  <= '0;
      period_ref <= '0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      sysref_out <= 1'b0;
      locked     <= 1'b0;
    end else begin
      q1 <= sysref_adc;
      q2 <= q1;
      if (state == S_IDLE)                    cnt <= '0;
      else if (sr_edge && state != S_ERROR)   cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)                cnt <= cnt + 1'b1;
      if (state == S_IDLE || ref_load) match_cnt <= '0;
      else if (match_inc)              match_cnt <= match_cnt + 1'b1;
      if (ref_load) period_ref <= cnt;
      if (state == S_ERROR && clear) begin
        err      <= 1'b0;
        err_code <= 2'd0;
      end else if (err_set) begin
        err      <= 1'b1;
        err_code <= code_nxt;
      end
      sysref_out <= fire;
      locked     <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_sysref_lock_ctrl.sv
// Bench for sysref_lock_ctrl: scenario tasks with inline checks, plus a queue of
// expected sysref_out cycles consumed by a negedge monitor.
module tb_sysref_lock_ctrl;
  localparam int CNT_W = 8;

  logic             pl_clk = 1'b0;
  logic             pl_rstn, sysref_adc, arm, clear;
  logic             sysref_out, locked, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] period_ref;
  logic [2:0]       state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int exp_q[$];
  int mon_exp;

  sysref_lock_ctrl #(
    .CNT_W(CNT_W), .LOCK_EDGES(4), .PERIOD_TOL(1), .MIN_PERIOD(4)
  ) dut (
    .pl_clk(pl_clk), .pl_rstn(pl_rstn), .sysref_adc(sysref_adc), .arm(arm),
    .clear(clear), .sysref_out(sysref_out), .locked(locked), .err(err),
    .err_code(err_code), .period_ref(period_ref), .state(state)
  );

  always #5 pl_clk = ~pl_clk;
  always @(posedge pl_clk) cyc <= cyc + 1;

  // Every sysref_out pulse must match the next expected cycle in the queue.
  always @(negedge pl_clk) begin
    if (sysref_out === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sysref_out_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cyc !== mon_exp) begin
          n_bad++;
          $display("FAIL sysref_out_timing: pulse at cycle %0d, required %0d", cyc, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pl_clk);
    #1;
  endtask

  // Rise lands in q1 one edge later and is acted on the edge after that.
  task automatic send_pulse(input bit fwd);
    sysref_adc = 1'b1;
    if (fwd) exp_q.push_back(cyc + 2);
    tick();
    sysref_adc = 1'b0;
  endtask

  task automatic test_reset();
    pl_rstn = 1'b0; sysref_adc = 1'b0; arm = 1'b0; clear = 1'b0;
    repeat (3) tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (sysref_out !== 1'b0) begin n_bad++; $display("FAIL reset_sysref_out: got %b want 0", sysref_out); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    n_cmp++; if (period_ref !== '0) begin n_bad++; $display("FAIL reset_period_ref: got %0d want 0", period_ref); end
    pl_rstn = 1'b1;
    tick();
  endtask

  task automatic test_clean_lock();
    int rest;
    arm = 1'b1;
    repeat (2) tick();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL clean_wait_first: got %0d want 1", state); end
    for (int i = 0; i < 10; i++) begin
      send_pulse(i >= 6);
      rest = 9;
      if (i == 2) begin
        n_cmp++; if (period_ref !== 8'd10) begin n_bad++; $display("FAIL clean_period_ref: got %0d want 10", period_ref); end
      end
      if (i == 5) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL clean_locked_early: got %b want 0", locked); end
        tick();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL clean_locked_rise: got %b want 1", locked); end
        rest = 8;
      end
      if (i == 7) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL clear_outside_error: got %0d want 4", state); end
        rest = 8;
      end
      if (i < 9) repeat (rest) tick();
    end
  endtask

  task automatic test_missing_edge();
    repeat (12) tick();
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL missing_still_locked: got %0d want 4", state); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL missing_err: got %b want 1", err); end
    n_cmp++; if (err_code !== 2'd3) begin n_bad++; $display("FAIL missing_err_code: got %0d want 3", err_code); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL missing_locked: got %b want 0", locked); end
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL missing_state: got %0d want 5", state); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL clear_to_idle: got %0d want 0", state); end
    n_cmp++; if (err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL clear_err: got %b/%0d want 0/0", err, err_code); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL rearm_wait_first: got %0d want 1", state); end
  endtask

  task automatic test_jitter();
    int gaps[9];
    gaps = '{10, 11, 9, 10, 11, 9, 11, 10, 12};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL jitter_locked: got %b want 1", locked); end
      end
      send_pulse(i >= 6 && i <= 8);
      if (i < 9) repeat (gaps[i] - 1) tick();
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL jitter_err_early: got %b want 0", err); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL jitter_err: got %b want 1", err); end
    n_cmp++; if (err_code !== 2'd3) begin n_bad++; $display("FAIL jitter_err_code: got %0d want 3", err_code); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL jitter_unlock: got %b want 0", locked); end
    n_cmp++; if (sysref_out !== 1'b0) begin n_bad++; $display("FAIL jitter_no_forward: got %b want 0", sysref_out); end
    clear = 1'b1; arm = 1'b0;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_short_period();
    pl_rstn = 1'b0;
    tick();
    pl_rstn = 1'b1;
    n_cmp++; if (period_ref !== '0) begin n_bad++; $display("FAIL short_ref_reset: got %0d want 0", period_ref); end
    arm = 1'b1;
    repeat (2) tick();
    send_pulse(1'b0);
    repeat (2) tick();
    send_pulse(1'b0);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL short_measure: got %0d want 2", state); end
    tick();
    n_cmp++; if (err !== 1'b1 || err_code !== 2'd2) begin n_bad++; $display("FAIL short_err_code: got %b/%0d want 1/2", err, err_code); end
    n_cmp++; if (period_ref !== '0) begin n_bad++; $display("FAIL short_period_ref: got %0d want 0", period_ref); end
    arm = 1'b0;
    repeat (3) tick();
    n_cmp++; if (state !== 3'd5 || err !== 1'b1) begin n_bad++; $display("FAIL error_ignores_arm: got %0d/%b want 5/1", state, err); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (state !== 3'd0 || err !== 1'b0) begin n_bad++; $display("FAIL short_clear: got %0d/%b want 0/0", state, err); end
  endtask

  task automatic test_timeout();
    arm = 1'b1;
    repeat (256) tick();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL timeout_early: got %0d want 1", state); end
    tick();
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL timeout_state: got %0d want 5", state); end
    n_cmp++; if (err !== 1'b1 || err_code !== 2'd1) begin n_bad++; $display("FAIL timeout_err_code: got %b/%0d want 1/1", err, err_code); end
    clear = 1'b1; arm = 1'b0;
    tick();
    clear = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL timeout_clear: got %0d want 0", state); end
    tick();
  endtask

  task automatic test_arm_drop();
    arm = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      send_pulse(1'b0);
      if (i < 2) repeat (9) tick();
    end
    tick();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL armdrop_verify: got %0d want 3", state); end
    arm = 1'b0;
    tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL armdrop_idle: got %0d want 0", state); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL armdrop_err: got %b want 0", err); end
    tick();
  endtask

  task automatic test_async_reset();
    arm = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 7; i++) begin
      send_pulse(i == 6);
      if (i < 6) repeat (9) tick();
    end
    tick();
    @(negedge pl_clk);
    n_cmp++; if (sysref_out !== 1'b1 || locked !== 1'b1) begin n_bad++; $display("FAIL async_pre: got %b/%b want 1/1", sysref_out, locked); end
    #1 pl_rstn = 1'b0;
    #1;
    n_cmp++; if (locked !== 1'b0 || sysref_out !== 1'b0) begin n_bad++; $display("FAIL async_outputs: got %b/%b want 0/0", locked, sysref_out); end
    n_cmp++; if (err !== 1'b0 || period_ref !== '0) begin n_bad++; $display("FAIL async_err_ref: got %b/%0d want 0/0", err, period_ref); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL async_state: got %0d want 0", state); end
    arm = 1'b0;
    #1 pl_rstn = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_missing_edge();
    test_jitter();
    test_short_period();
    test_timeout();
    test_arm_drop();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sysref_out_missing: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
